ram_responder: RTL
==================

RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, meaning address width; array depth is 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter LATENCY, default 4, meaning clock edges from request acceptance to completion; legal range 1..15.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port re  input  1  read request from the cache miss path.
REQ-007 SHALL have port we  input  1  write request (write-through / fill path).
REQ-008 SHALL have port addr  input  ADDR_WIDTH  request word address.
REQ-009 SHALL have port data_in  input  WIDTH  write data.
REQ-010 SHALL have port data_out  output  WIDTH  read data, registered.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse for the current request.
REQ-012 SHALL have port busy  output  1  high whenever a request is in flight (state != IDLE).

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-014 SHALL, in IDLE, accept a request on a rising edge where re or we is high: latch addr, data_in and operation, load the counter with LATENCY-1, and go to WAIT.
REQ-015 SHALL treat re and we both high at acceptance as a write; the read is dropped.
REQ-016 SHALL, in WAIT, decrement the counter each edge and go to DONE on the edge where the counter equals 0. With LATENCY=1 this is the edge right after acceptance.
REQ-017 SHALL, on the WAIT->DONE edge, commit a latched write to the array, or load data_out from the array at the latched address for a latched read.
REQ-018 SHALL assert done for exactly the one cycle spent in DONE; done is a register output, not decoded from inputs.
REQ-019 SHALL return from DONE to IDLE on the next edge unconditionally; re/we seen in WAIT or DONE are ignored, not queued.
REQ-020 SHALL therefore give a request accepted at edge T: done high between edges T+LATENCY and T+LATENCY+1; earliest next acceptance at edge T+LATENCY+2.
REQ-021 SHALL hold data_out between reads; writes do not change data_out.
REQ-022 SHALL sample only the latched addr and data; input changes after acceptance have no effect.
REQ-023 SHALL make a read following a write to the same address return the written value; there is no stale path.
REQ-024 SHALL size the counter to $clog2(LATENCY+1) bits, with no wrap-around in legal use.

Reset
REQ-025 SHALL, while rst=0 and regardless of clk, force state=IDLE, counter=0, done=0, busy=0, data_out=0.
REQ-026 SHALL, on reset, initialise array word i to i truncated to WIDTH bits, giving distinguishable fill data.
REQ-027 SHALL abort an in-flight request on reset mid-operation: no write committed, no done pulse; the first request after release is handled normally.

Verification
REQ-028 SHALL cover read latency: LATENCY=4, reset, re=1 addr=5 at edge T -> busy=1 from T; done=1 only in cycle after edge T+4; data_out=8'h05.
REQ-029 SHALL cover write then read: we=1 addr=3 data_in=8'hA7, wait for done, then re=1 addr=3 -> second done shows data_out=8'hA7; data_out unchanged during the write's done.
REQ-030 SHALL cover simultaneous re/we: re=we=1 addr=9 data_in=8'h3C -> done once, data_out stays at its prior value; later read addr=9 returns 8'h3C.
REQ-031 SHALL cover busy-time requests: re pulsed with addr=1 at T+1 and T+3 during a read of addr=2 -> exactly one done, data_out=8'h02; no second done follows.
REQ-032 SHALL cover reset mid-write: we addr=4 data=8'hFF, rst=0 at T+2 -> done never pulses, outputs are 0 immediately; after release, read addr=4 returns 8'h04.
REQ-033 SHALL cover LATENCY=1: re addr=7 at T -> done in cycle after T+1, data_out=8'h07; back-to-back re accepted at T+3.

Source files
------------

// File: rtl/ram_responder_if.sv
// Request/response bundle between a cache miss path and the RAM responder.
interface ram_responder_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 6
);
    logic                  re;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      data_in;
    logic [WIDTH-1:0]      data_out;
    logic                  done;
    logic                  busy;

    modport master (
        output re, we, addr, data_in,
        input  data_out, done, busy
    );

    modport slave (
        input  re, we, addr, data_in,
        output data_out, done, busy
    );
endinterface

// File: rtl/ram_responder.sv
// Fixed-latency RAM model: accepts one read or write, completes LATENCY edges later
// with a single done pulse; requests arriving while busy are dropped.
module ram_responder #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int LATENCY    = 4
) (
    input  logic            clk,
    input  logic            rst,
    ram_responder_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                state;
    state_t                state_next;
    logic [CNT_W-1:0]      cnt;
    logic                  op_write;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WIDTH-1:0]      data_q;
    logic [WIDTH-1:0]      data_out_q;
    logic [WIDTH-1:0]      mem [DEPTH];
    logic                  accept;
    logic                  finish;

    assign accept = (state == IDLE) && (bus.re || bus.we);
    assign finish = (state == WAIT) && (cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = WAIT;
            WAIT:    if (finish) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.done     = (state == DONE);
        bus.busy     = (state != IDLE);
        bus.data_out = data_out_q;
    end

    // Array reset to its own index so fill data is distinguishable per word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            op_write   <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            data_out_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= WIDTH'(i);
            end
        end else begin
            if (accept) begin
                cnt      <= CNT_W'(LATENCY - 1);
                op_write <= bus.we;
                addr_q   <= bus.addr;
                data_q   <= bus.data_in;
            end else if (state == WAIT && !finish) begin
                cnt <= cnt - 1'b1;
            end
            if (finish) begin
                if (op_write) begin
                    mem[addr_q] <= data_q;
                end else begin
                    data_out_q <= mem[addr_q];
                end
            end
        end
    end
endmodule
